// File: rtl/score_pkg.sv
// score_pkg: shared definitions for the score overlay.
//   seg_e           - seven-segment index, SEG_A (top) .. SEG_G (middle)
//   DIGIT_SEGS      - segment patterns for 0-9, bit n lights segment seg_e'(n)
//   COLOR_BLACK/WHITE - 6-bit RGB colours common to the overlay generators
//   seg_pattern()   - digit to segment pattern; codes above 9 render unlit
package score_pkg;

   typedef enum logic [2:0] {
      SEG_A = 3'd0,
      SEG_B = 3'd1,
      SEG_C = 3'd2,
      SEG_D = 3'd3,
      SEG_E = 3'd4,
      SEG_F = 3'd5,
      SEG_G = 3'd6
   } seg_e;

   // Bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] DIGIT_SEGS [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   localparam logic [5:0] COLOR_BLACK = 6'b000000;
   localparam logic [5:0] COLOR_WHITE = 6'b111111;

   function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
      if (digit <= 4'd9)
         return DIGIT_SEGS[digit];
      else
         return 7'h00;
   endfunction

endpackage

// File: rtl/score_display_if.sv
// score_display_if: game-logic / video-timing side of the score overlay.
//   master : drives col, row, valid, frame_start, add_en, add_amt, clear;
//            reads score, busy, rgb
//   slave  : the overlay itself (score_display)
interface score_display_if #(
   parameter int SCORE_W = 17
);
   logic [9:0]         col;
   logic [9:0]         row;
   logic               valid;
   logic               frame_start;
   logic               add_en;
   logic [7:0]         add_amt;
   logic               clear;
   logic [SCORE_W-1:0] score;
   logic               busy;
   logic [5:0]         rgb;

   modport master (
      output col, row, valid, frame_start, add_en, add_amt, clear,
      input  score, busy, rgb
   );

   modport slave (
      input  col, row, valid, frame_start, add_en, add_amt, clear,
      output score, busy, rgb
   );
endinterface

// File: rtl/seg_glyph.sv
// seg_glyph: combinational seven-segment glyph test.
//   digit : BCD value to draw (codes above 9 draw nothing)
//   x, y  : pixel position relative to the top-left corner of the cell
//   lit   : 1 when (x, y) falls on a segment that is on for this digit
// The caller guarantees (x, y) is inside the DIGIT_W x DIGIT_H cell.
module seg_glyph
   import score_pkg::*;
#(
   parameter int DIGIT_W = 22,
   parameter int DIGIT_H = 40,
   parameter int SEG_T   = 4
) (
   input  logic [3:0] digit,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic       lit
);

   // Middle bar is centred on DIGIT_H/2
   localparam int MID_TOP = DIGIT_H / 2 - SEG_T / 2;

   logic [6:0] pat;
   logic [6:0] on;
   logic       upper;
   logic       left;
   logic       right;

   always_comb begin
      pat   = seg_pattern(digit);
      upper = (y < 10'(DIGIT_H / 2));
      left  = (x < 10'(SEG_T));
      right = (x >= 10'(DIGIT_W - SEG_T));
      on          = '0;
      on[SEG_A]   = (y < 10'(SEG_T));
      on[SEG_B]   = right && upper;
      on[SEG_C]   = right && !upper;
      on[SEG_D]   = (y >= 10'(DIGIT_H - SEG_T));
      on[SEG_E]   = left && !upper;
      on[SEG_F]   = left && upper;
      on[SEG_G]   = (y >= 10'(MID_TOP)) && (y < 10'(MID_TOP + SEG_T));
      lit   = |(on & pat);
   end

endmodule

// File: rtl/score_display.sv
// score_display: game score register plus seven-segment score overlay.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   bus        : score_display_if.slave
//                col/row/valid      - pixel position and active-video flag
//                frame_start        - once-per-frame pulse (blanking only)
//                add_en/add_amt     - add to the score, saturating at 10^N-1
//                clear              - zero the score, wins over add_en
//                score, busy        - score register, conversion in progress
//                rgb                - registered pixel colour (1-cycle latency)
// The score is converted to BCD by a sequential double-dabble once per
// frame; rendering reads only the latched display digits.
module score_display
   import score_pkg::*;
#(
   parameter int         NUM_DIGITS = 5,
   parameter int         SCORE_W    = 17,
   parameter int         X0         = 20,
   parameter int         Y0         = 70,
   parameter int         PITCH      = 26,
   parameter int         DIGIT_W    = 22,
   parameter int         DIGIT_H    = 40,
   parameter int         SEG_T      = 4,
   parameter logic [5:0] FG         = COLOR_WHITE,
   parameter int         BLANK_LZ   = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   score_display_if.slave  bus
);

   localparam int               BCD_W   = 4 * NUM_DIGITS;
   localparam int               CNT_W   = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
   localparam int               MAX_INT = 10 ** NUM_DIGITS - 1;
   localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W + 1)'(MAX_INT);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

   state_e             state;
   logic               busy;
   logic [SCORE_W-1:0] score_q;
   logic [SCORE_W-1:0] snap;
   logic [BCD_W-1:0]   bcd;
   logic [BCD_W-1:0]   disp;
   logic [CNT_W-1:0]   cnt;
   logic [5:0]         rgb_q;

   // Add in SCORE_W+1 bits so the carry is visible, then clamp.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                  input logic [7:0]         a);
      logic [SCORE_W:0] sum;
      sum = {1'b0, s} + (SCORE_W + 1)'(a);
      if (sum > MAX_EXT)
         return MAX_EXT[SCORE_W-1:0];
      else
         return sum[SCORE_W-1:0];
   endfunction

   // One double-dabble iteration: correct nibbles >= 5, then shift in_bit in.
   function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] acc,
                                               input logic             in_bit);
      logic [BCD_W-1:0] adj;
      adj = acc;
      for (int n = 0; n < NUM_DIGITS; n++) begin
         if (adj[4*n +: 4] >= 4'd5)
            adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
      end
      return {adj[BCD_W-2:0], in_bit};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         score_q <= '0;
      else if (bus.clear)
         score_q <= '0;
      else if (bus.add_en)
         score_q <= sat_add(score_q, bus.add_amt);
   end

   // Conversion FSM. frame_start is only honoured in IDLE, so a pulse
   // arriving mid-conversion cannot restart or disturb it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         snap  <= '0;
         bcd   <= '0;
         cnt   <= '0;
         disp  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.frame_start) begin
                  snap  <= score_q;
                  bcd   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               bcd  <= dabble(bcd, snap[SCORE_W-1]);
               snap <= {snap[SCORE_W-2:0], 1'b0};
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_W'(SCORE_W - 1))
                  state <= LATCH;
            end
            LATCH: begin
               disp  <= bcd;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // A digit is blanked while it and every more-significant digit are zero;
   // the least significant digit is always drawn.
   logic [NUM_DIGITS-1:0] blank;
   logic                  lead;

   always_comb begin
      blank = '0;
      lead  = (BLANK_LZ != 0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         lead = lead && (disp[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
         if (i != NUM_DIGITS - 1)
            blank[i] = lead;
      end
   end

   // Cell hit test; cells never overlap because DIGIT_W <= PITCH.
   logic       hit;
   logic       in_band;
   logic       sel_blank;
   logic [3:0] sel_digit;
   logic [9:0] cell_x;
   logic [9:0] cell_y;
   logic       lit;

   always_comb begin
      hit       = 1'b0;
      sel_blank = 1'b1;
      sel_digit = 4'd0;
      cell_x    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (({1'b0, bus.col} >= 11'(X0 + i * PITCH)) &&
             ({1'b0, bus.col} <  11'(X0 + i * PITCH + DIGIT_W))) begin
            hit       = 1'b1;
            sel_blank = blank[i];
            sel_digit = disp[4*(NUM_DIGITS-1-i) +: 4];
            cell_x    = bus.col - 10'(X0 + i * PITCH);
         end
      end
      in_band = ({1'b0, bus.row} >= 11'(Y0)) && ({1'b0, bus.row} < 11'(Y0 + DIGIT_H));
      cell_y  = bus.row - 10'(Y0);
   end

   seg_glyph #(
      .DIGIT_W (DIGIT_W),
      .DIGIT_H (DIGIT_H),
      .SEG_T   (SEG_T)
   ) u_glyph (
      .digit (sel_digit),
      .x     (cell_x),
      .y     (cell_y),
      .lit   (lit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rgb_q <= COLOR_BLACK;
      else if (bus.valid && in_band && hit && !sel_blank && lit)
         rgb_q <= FG;
      else
         rgb_q <= COLOR_BLACK;
   end

   assign bus.score = score_q;
   assign bus.busy  = busy;
   assign bus.rgb   = rgb_q;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed self-checking bench for score_display with
// default parameters (5 digits, 17-bit score, cells at columns 20/46/72/98/124,
// band rows 70..109).
module tb_score_display;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   score_display_if #(.SCORE_W(17)) bus ();

   score_display #(
      .NUM_DIGITS (5),
      .SCORE_W    (17)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one pixel for a cycle and compare the registered colour.
   task automatic pix(input string tag, input int c, input int r, input logic [5:0] exp);
      bus.col   = 10'(c);
      bus.row   = 10'(r);
      bus.valid = 1'b1;
      tick();
      check(tag, 32'(bus.rgb), 32'(exp));
      bus.valid = 1'b0;
   endtask

   task automatic do_frame(input string tag);
      int n;
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      n = 0;
      while (bus.busy && n < 40) begin
         tick();
         n++;
      end
      check(tag, 32'(bus.busy), 32'd0);
   endtask

   task automatic add(input int amt, input int times);
      bus.add_en  = 1'b1;
      bus.add_amt = 8'(amt);
      repeat (times) tick();
      bus.add_en  = 1'b0;
   endtask

   int hi;
   int first_low;

   initial begin
      rst_n           = 1'b0;
      bus.col         = '0;
      bus.row         = '0;
      bus.valid       = 1'b0;
      bus.frame_start = 1'b0;
      bus.add_en      = 1'b0;
      bus.add_amt     = '0;
      bus.clear       = 1'b0;
      tick();
      tick();
      check("reset_score", 32'(bus.score), 32'd0);
      check("reset_busy",  32'(bus.busy),  32'd0);
      check("reset_rgb",   32'(bus.rgb),   32'd0);
      rst_n = 1'b1;
      tick();

      // Zero score: only the LSD draws
      do_frame("frame0_done");
      pix("lsd0_seg_a",      126, 71, 6'b111111);
      pix("msd0_blank_a",     22, 71, 6'b000000);
      pix("msd0_blank_f",     20, 75, 6'b000000);
      pix("gap_after_lsd",   146, 71, 6'b000000);
      bus.col = 10'd126; bus.row = 10'd71; bus.valid = 1'b0;
      tick();
      check("lsd0_not_valid", 32'(bus.rgb), 32'd0);

      // 9 back-to-back adds of 200
      add(200, 1);
      check("score_200", 32'(bus.score), 32'd200);
      add(200, 8);
      check("score_1800", 32'(bus.score), 32'd1800);
      do_frame("frame1800_done");
      pix("d0_blank",        22, 71, 6'b000000);
      pix("d1_one_b",        66, 80, 6'b111111);
      pix("d1_one_no_a",     47, 71, 6'b000000);
      pix("d2_eight_g",      82, 89, 6'b111111);
      pix("d3_zero_no_g",   108, 89, 6'b000000);
      pix("d3_zero_a",      108, 71, 6'b111111);
      pix("d4_zero_d",      128, 109, 6'b111111);
      pix("below_band",     128, 110, 6'b000000);

      // Saturation and clear priority
      bus.clear = 1'b1; tick(); bus.clear = 1'b0;
      check("clear_only", 32'(bus.score), 32'd0);
      add(255, 392);
      add(30, 1);
      check("score_99990", 32'(bus.score), 32'd99990);
      add(255, 1);
      check("saturate_99999", 32'(bus.score), 32'd99999);
      add(1, 1);
      check("hold_99999", 32'(bus.score), 32'd99999);
      bus.clear = 1'b1; bus.add_en = 1'b1; bus.add_amt = 8'd50;
      tick();
      bus.clear = 1'b0; bus.add_en = 1'b0;
      check("clear_beats_add", 32'(bus.score), 32'd0);

      // Second frame_start during SHIFT is ignored
      bus.frame_start = 1'b1;
      tick();
      hi        = int'(bus.busy);
      first_low = -1;
      for (int j = 1; j <= 25; j++) begin
         bus.frame_start = (j == 5);
         tick();
         if (bus.busy) hi++;
         else if (first_low < 0) first_low = j;
      end
      bus.frame_start = 1'b0;
      check("busy_high_count", 32'(hi), 32'd18);
      check("busy_first_low",  32'(first_low), 32'd18);

      // Score change mid-conversion shows only after the next frame
      add(123, 1);
      bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
      tick(); tick();
      add(100, 1);
      check("score_223", 32'(bus.score), 32'd223);
      while (bus.busy) tick();
      pix("s123_d1_blank",   48, 71, 6'b000000);
      pix("s123_d2_no_a",    74, 71, 6'b000000);
      pix("s123_d2_b",       92, 80, 6'b111111);
      pix("s123_d2_no_e",    73, 100, 6'b000000);
      pix("s123_d3_g",      108, 89, 6'b111111);
      pix("s123_d4_no_e",   125, 100, 6'b000000);
      pix("s123_d4_c",      144, 100, 6'b111111);
      do_frame("frame223_done");
      pix("s223_d2_e",       73, 100, 6'b111111);

      // Reset in the middle of SHIFT
      bus.col = 10'd73; bus.row = 10'd100; bus.valid = 1'b1;
      bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
      repeat (8) tick();
      check("pre_reset_busy", 32'(bus.busy), 32'd1);
      check("pre_reset_rgb",  32'(bus.rgb),  32'd63);
      rst_n = 1'b0;
      #1;
      check("mid_reset_busy",  32'(bus.busy),  32'd0);
      check("mid_reset_rgb",   32'(bus.rgb),   32'd0);
      check("mid_reset_score", 32'(bus.score), 32'd0);
      bus.valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      pix("post_reset_lsd_a",  126, 71, 6'b111111);
      pix("post_reset_d2_e",    73, 100, 6'b000000);
      pix("post_reset_d0",      22, 71, 6'b000000);
      check("post_reset_busy", 32'(bus.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_display.md
# score_display

Parametrised successor to the fixed five-digit score overlay. It owns the game score register (add, clear, saturate) and converts it to BCD with a sequential double-dabble engine once per frame. It renders the digits as seven-segment glyphs at a configurable screen position, with a registered 6-bit RGB pixel output. It sits between the game logic and the VGA pixel mux, in the same col/row/valid pixel domain as the other overlay generators.

## Interface
- NUM_DIGITS, 5, number of decimal digits displayed (1–6)
- SCORE_W, 17, score register width; must satisfy 2^SCORE_W > 10^NUM_DIGITS − 1
- X0, 20, left column of digit 0 (the most significant digit)
- Y0, 70, top row of the digit band
- PITCH, 26, column stride between digit cells
- DIGIT_W, 22, glyph width in pixels (≤ PITCH)
- DIGIT_H, 40, glyph height in pixels
- SEG_T, 4, segment thickness in pixels
- FG, 6'b111111, lit-segment colour
- BLANK_LZ, 1, 1 = blank leading zeros
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- col  in  10  current pixel column
- row  in  10  current pixel row
- valid  in  1  active-video qualifier
- frame_start  in  1  one-cycle pulse, once per frame, issued during blanking
- add_en  in  1  one-cycle pulse: add add_amt to the score
- add_amt  in  8  unsigned increment
- clear  in  1  synchronous score clear
- score  out  SCORE_W  current score register
- busy  out  1  BCD conversion in progress
- rgb  out  6  pixel colour, 2 bits each of R, G, B

## Operation
- Score register
  - clear has priority over add_en.
  - add computes score + add_amt in SCORE_W+1 bits, then saturates at MAX = 10^NUM_DIGITS − 1.
  - clear and add_en asserted together: the score becomes 0.
- Conversion FSM states: IDLE, SHIFT, LATCH.
  - IDLE: on frame_start, snapshot score into a shift register, zero the BCD accumulator, go to SHIFT.
  - SHIFT: SCORE_W iterations. In each, add 3 to every BCD nibble ≥ 5, then shift left one bit with the MSB of the snapshot entering. After the last iteration, go to LATCH.
  - LATCH: copy the BCD accumulator into the display digit registers, return to IDLE.
  - frame_start while not IDLE is ignored; the conversion in flight completes unchanged.
  - Score changes during a conversion do not affect it; they are shown after the next frame_start.
- Rendering reads only the display digit registers, so a digit never changes mid-frame unless frame_start is issued during active video (not permitted).
- Cell i (0 = MSD) spans columns X0+i·PITCH … X0+i·PITCH+DIGIT_W−1 and rows Y0 … Y0+DIGIT_H−1.
  - Inside a cell, local (x, y) and the digit value feed the glyph sub-module.
  - Seven segments a–g: horizontal bars are SEG_T tall, at the top, the middle (centred on DIGIT_H/2) and the bottom. Vertical bars are SEG_T wide, at the left and right edges, upper and lower halves.
  - Standard seven-segment maps for 0–9; the decimal point is not used.
- Leading-zero blanking (BLANK_LZ = 1): a digit renders unlit if it and all more-significant digits are 0. The least significant digit always renders.
- rgb = FG on a lit segment pixel with valid = 1; otherwise 6'b000000. This includes the gaps between cells and everything outside the band.
- Reset values:
  - score = 0
  - display digits = 0
  - FSM = IDLE, busy = 0
  - rgb = 0, shift and BCD registers = 0
- Reset asserted mid-conversion aborts it; the display shows 0 after release.

## Timing
- score updates on the clock edge after the add_en/clear cycle.
- Conversion, with frame_start sampled at edge k:
  - busy = 1 from cycle k+1 through k+SCORE_W+1 (SHIFT, then LATCH).
  - New digits are visible from cycle k+SCORE_W+2. For SCORE_W = 17 that is 19 cycles, well inside any blanking interval.
- rgb is registered: latency one clock from col/row/valid to rgb. The pixel mux aligns its other sources to match.
- No backpressure: add_en is accepted on every cycle, including back-to-back.

## Structure
- Package score_pkg: the segment enum (SEG_A..SEG_G), the 7-bit segment-pattern constants for 0–9, and the colour constants shared with the other overlay generators.
- One sub-module, seg_glyph: combinational; inputs digit[3:0], x, y, DIGIT_W, DIGIT_H, SEG_T; output lit. One instance is shared. The cell index and local coordinates are computed in the parent, and the parent muxes the digit value in.
- The double-dabble FSM and the score register stay in score_display.

## Test plan
- Reset, then frame_start; pixel (X0+NUM_DIGITS·PITCH−PITCH+2, Y0+1) is in segment a of the LSD → rgb = 6'b111111 one cycle later, and every MSD cell pixel is 0 (blanked zeros).
- add_en with add_amt = 200, 9 times; score = 1800. After frame_start + 19 cycles, the digits are 0,1,8,0,0 and the leading zero is blanked.
- score = 99990, add_amt = 255 → score saturates at 99999. Then clear and add_en in the same cycle → score = 0.
- frame_start at cycle k and again at k+5 → busy stays high continuously for 18 cycles (k+1 … k+18), with no restart and no glitch.
- add_en during SHIFT changes score while the displayed digits keep the snapshot value until the next conversion completes.
- rst_n asserted at SHIFT iteration 8 → busy = 0 and rgb = 0 immediately. After release, the display shows a single "0".
